uart_tx_arbiter: RTL

//  Shares one uart_tx byte transmitter between N_REQ requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between N_REQ
// valid/ready requesters, with message locking and a WAIT-state watchdog.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned TIMEOUT = 60000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [7:0]         uart_data_in,
   output logic               uart_tx_start,
   input  logic               uart_tx_done,
   input  logic               err_clr,
   output logic [ID_W-1:0]    grant_id,
   output logic               busy,
   output logic               timeout_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam logic [15:0]     WD_LAST  = 16'(TIMEOUT - 1);
   localparam logic [ID_W:0]   NREQ_W   = (ID_W+1)'(N_REQ);
   localparam logic [ID_W-1:0] NREQ_M1  = ID_W'(N_REQ - 1);

   state_t          r_state;
   logic            r_lock;
   logic [ID_W-1:0] r_rr_ptr;
   logic [ID_W-1:0] r_grant_id;
   logic [15:0]     r_wd_cnt;
   logic [7:0]      r_data;
   logic            r_start;
   logic            r_busy;
   logic            r_timeout_err;

   logic            w_found;
   logic [ID_W-1:0] w_win;
   logic [ID_W:0]   w_sum;
   logic [7:0]      w_byte;
   logic            w_last;
   logic [ID_W-1:0] w_next_ptr;
   logic [N_REQ-1:0] w_ready;

   // Winner search: locked -> only the holder; otherwise first valid from rr_ptr, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_rr_ptr;
      w_sum   = '0;
      if (r_lock) begin
         w_found = req_valid[r_grant_id];
         w_win   = r_grant_id;
      end else begin
         for (int unsigned k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
            if (!w_found && req_valid[w_sum[ID_W-1:0]]) begin
               w_found = 1'b1;
               w_win   = w_sum[ID_W-1:0];
            end
         end
      end
   end

   // Byte/last of the winner, next round-robin pointer and the one-hot ready.
   always_comb begin
      w_byte  = '0;
      w_ready = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (w_win == ID_W'(i)) w_byte = req_data[8*i +: 8];
      end
      w_last     = req_last[w_win];
      w_next_ptr = (w_win == NREQ_M1) ? '0 : w_win + 1'b1;
      if (r_state == IDLE && w_found && !reset) w_ready[w_win] = 1'b1;
   end

   // Arbiter FSM with registered outputs and watchdog.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_lock        <= 1'b0;
         r_rr_ptr      <= '0;
         r_grant_id    <= '0;
         r_wd_cnt      <= '0;
         r_data        <= '0;
         r_start       <= 1'b0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         // Clear first so a same-cycle timeout below takes precedence.
         if (err_clr) r_timeout_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_data     <= w_byte;
                  r_grant_id <= w_win;
                  r_rr_ptr   <= w_next_ptr;
                  r_lock     <= ~w_last;
                  r_start    <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ISSUE;
               end
            end
            ISSUE: begin
               r_start  <= 1'b0;
               r_wd_cnt <= '0;
               r_state  <= WAIT;
            end
            WAIT: begin
               if (uart_tx_done) begin
                  r_state <= GAP;
               end else if (r_wd_cnt == WD_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_lock        <= 1'b0;
                  r_state       <= GAP;
               end else begin
                  r_wd_cnt <= r_wd_cnt + 16'd1;
               end
            end
            GAP: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready     = w_ready;
   assign uart_data_in  = r_data;
   assign uart_tx_start = r_start;
   assign grant_id      = r_grant_id;
   assign busy          = r_busy;
   assign timeout_err   = r_timeout_err;

endmodule
